// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the voltmeter conversion path.
package voltmeter_pkg;

  localparam int COUNT_W_DEFAULT = 12;
  localparam int AVG_MAX_LOG2    = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_PUBLISH   = 3'd4,
    ST_GAP       = 3'd5
  } sched_state_t;

  // Accumulator must hold 2^AVG_MAX_LOG2 full-scale samples without wrapping.
  function automatic int acc_width(input int count_w);
    return count_w + AVG_MAX_LOG2;
  endfunction

endpackage

// File: rtl/conversion_scheduler_interval_timer.sv
// Loadable down-counter; done_o flags the last running cycle of the interval.
module interval_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         done_o
);

  logic [W-1:0] cnt;

  // Load has priority; counting stops at zero so a zero load never expires.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (run_i && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_o = run_i && (cnt == W'(1));

endmodule

// File: rtl/conversion_scheduler.sv
// Conversion sequencer: triggers the measurement FSM, averages 1/2/4/8 samples,
// supports single-shot and periodic bursts with a per-conversion timeout.
module conversion_scheduler
  import voltmeter_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEFAULT,
  parameter int PERIOD_W  = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 single_shot_i,
  input  logic                 continuous_i,
  input  logic [1:0]           avg_log2_i,
  input  logic [PERIOD_W-1:0]  period_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 err_clr_i,
  output logic                 trigger_o,
  input  logic                 digital_ready_i,
  input  logic [COUNT_W-1:0]   measurement_count_i,
  output logic [COUNT_W-1:0]   result_o,
  output logic                 result_valid_o,
  output logic                 busy_o,
  output logic [2:0]           sample_idx_o,
  output logic                 timeout_err_o
);

  localparam int ACC_W = acc_width(COUNT_W);

  sched_state_t state, next_state;

  logic [1:0]           avg_l;
  logic [PERIOD_W-1:0]  period_l;
  logic [TIMEOUT_W-1:0] timeout_l;
  logic [ACC_W-1:0]     acc;
  logic [2:0]           sample_idx;
  logic [3:0]           n_samples;
  logic                 last_sample;
  logic                 in_wait;
  logic                 to_done;
  logic                 gap_done;
  logic [PERIOD_W-1:0]  gap_load;
  logic [COUNT_W-1:0]   avg_result;
  logic                 trigger_d;
  logic                 start_burst;
  logic                 sample_take;
  logic                 publish;
  logic                 timeout_hit;

  // sample_idx wraps to 0 after the 8th sample, so compare before incrementing.
  assign n_samples   = 4'd1 << avg_l;
  assign last_sample = (sample_idx == 3'(n_samples - 4'd1));
  assign in_wait     = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign gap_load    = (period_l == '0) ? PERIOD_W'(1) : period_l;
  assign avg_result  = COUNT_W'(acc >> avg_l);

  interval_timer #(.W(TIMEOUT_W)) u_timeout_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (state == ST_TRIG),
    .load_val_i (timeout_l),
    .run_i      (in_wait),
    .done_o     (to_done)
  );

  interval_timer #(.W(PERIOD_W)) u_gap_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (state != ST_GAP),
    .load_val_i (gap_load),
    .run_i      (state == ST_GAP),
    .done_o     (gap_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a completed conversion beats a coincident timeout.
  always_comb begin
    next_state = state;
    if (!enable_i) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (single_shot_i || continuous_i) next_state = ST_TRIG;
        ST_TRIG:      next_state = ST_WAIT_BUSY;
        ST_WAIT_BUSY: begin
          if (!digital_ready_i) next_state = ST_WAIT_DONE;
          else if (to_done)     next_state = continuous_i ? ST_GAP : ST_IDLE;
        end
        ST_WAIT_DONE: begin
          if (digital_ready_i) next_state = last_sample ? ST_PUBLISH : ST_TRIG;
          else if (to_done)    next_state = continuous_i ? ST_GAP : ST_IDLE;
        end
        ST_PUBLISH:   next_state = continuous_i ? ST_GAP : ST_IDLE;
        ST_GAP: begin
          if (!continuous_i) next_state = ST_IDLE;
          else if (gap_done) next_state = ST_TRIG;
        end
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // Per-cycle control strobes derived from state and handshake inputs.
  always_comb begin
    trigger_d   = (next_state == ST_TRIG);
    start_burst = (next_state == ST_TRIG) && ((state == ST_IDLE) || (state == ST_GAP));
    sample_take = enable_i && (state == ST_WAIT_DONE) && digital_ready_i;
    publish     = enable_i && (state == ST_PUBLISH);
    timeout_hit = enable_i && to_done &&
                  (((state == ST_WAIT_BUSY) && digital_ready_i) ||
                   ((state == ST_WAIT_DONE) && !digital_ready_i));
  end

  // Registered outputs, config latch, accumulator and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trigger_o      <= 1'b0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      timeout_err_o  <= 1'b0;
      avg_l          <= '0;
      period_l       <= '0;
      timeout_l      <= '0;
      acc            <= '0;
      sample_idx     <= '0;
    end else begin
      trigger_o      <= trigger_d;
      result_valid_o <= publish;
      if (publish) result_o <= avg_result;
      if (timeout_hit)    timeout_err_o <= 1'b1;
      else if (err_clr_i) timeout_err_o <= 1'b0;
      if (!enable_i) begin
        acc        <= '0;
        sample_idx <= '0;
      end else if (start_burst) begin
        avg_l      <= avg_log2_i;
        period_l   <= period_i;
        timeout_l  <= timeout_i;
        acc        <= '0;
        sample_idx <= '0;
      end else if (sample_take) begin
        acc        <= acc + ACC_W'(measurement_count_i);
        sample_idx <= sample_idx + 3'd1;
      end
    end
  end

  assign busy_o       = (state != ST_IDLE);
  assign sample_idx_o = sample_idx;

endmodule

// File: tb/tb_conversion_scheduler.sv
// Self-checking bench for conversion_scheduler with a behavioural model of the
// measurement state machine (ready handshake + sample values).
module tb_conversion_scheduler;

  localparam int COUNT_W   = 12;
  localparam int PERIOD_W  = 16;
  localparam int TIMEOUT_W = 20;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b1;
  logic                 enable_i = 1'b1;
  logic                 single_shot_i = 1'b0;
  logic                 continuous_i = 1'b0;
  logic [1:0]           avg_log2_i = '0;
  logic [PERIOD_W-1:0]  period_i = '0;
  logic [TIMEOUT_W-1:0] timeout_i = '0;
  logic                 err_clr_i = 1'b0;
  logic                 trigger_o;
  logic                 digital_ready_i = 1'b1;
  logic [COUNT_W-1:0]   measurement_count_i = '0;
  logic [COUNT_W-1:0]   result_o;
  logic                 result_valid_o;
  logic                 busy_o;
  logic [2:0]           sample_idx_o;
  logic                 timeout_err_o;

  conversion_scheduler #(
    .COUNT_W   (COUNT_W),
    .PERIOD_W  (PERIOD_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .enable_i            (enable_i),
    .single_shot_i       (single_shot_i),
    .continuous_i        (continuous_i),
    .avg_log2_i          (avg_log2_i),
    .period_i            (period_i),
    .timeout_i           (timeout_i),
    .err_clr_i           (err_clr_i),
    .trigger_o           (trigger_o),
    .digital_ready_i     (digital_ready_i),
    .measurement_count_i (measurement_count_i),
    .result_o            (result_o),
    .result_valid_o      (result_valid_o),
    .busy_o              (busy_o),
    .sample_idx_o        (sample_idx_o),
    .timeout_err_o       (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Written only by the model/monitor process.
  int cyc = 0;
  int trig_count = 0;
  int valid_count = 0;
  int done_count = 0;
  int last_trig_cyc = -1;
  int last_valid_cyc = -1;
  int last_done_cyc = -1;
  int low_at = -1;
  int high_at = -1;
  int trig_cycles[$];
  logic [COUNT_W-1:0] last_valid_val = '0;

  // Written only by the test sequence.
  int conv_len = 20;
  bit never_done = 1'b0;
  bit restore_ready = 1'b0;
  int val_base = 0;
  logic [COUNT_W-1:0] vals_q[$];
  logic [COUNT_W-1:0] model_result = '0;

  // Measurement FSM model: ready drops 3 cycles after a trigger and returns
  // conv_len cycles later carrying the next queued sample value.
  always @(negedge clk_i) begin
    int vi;
    cyc++;
    if (trigger_o === 1'b1) begin
      trig_count++;
      last_trig_cyc = cyc;
      trig_cycles.push_back(cyc);
      low_at  = cyc + 3;
      high_at = never_done ? -1 : cyc + 3 + conv_len;
    end
    if (result_valid_o === 1'b1) begin
      valid_count++;
      last_valid_cyc = cyc;
      last_valid_val = result_o;
    end
    if (restore_ready) digital_ready_i = 1'b1;
    if (cyc == low_at) digital_ready_i = 1'b0;
    if (cyc == high_at) begin
      vi = done_count - val_base;
      measurement_count_i = (vi >= 0 && vi < vals_q.size()) ? vals_q[vi] : '0;
      digital_ready_i = 1'b1;
      last_done_cyc = cyc;
      done_count++;
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic pulse_ss(input logic [1:0] avg, output int c);
    avg_log2_i    = avg;
    single_shot_i = 1'b1;
    c = cyc;
    tick();
    single_shot_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n_i = 1'b0;
    repeat (3) tick();
    checks++; if (trigger_o !== 1'b0)      begin errors++; $display("FAIL rst_trigger got %0h want 0", trigger_o); end
    checks++; if (result_o !== '0)         begin errors++; $display("FAIL rst_result got %0h want 0", result_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", result_valid_o); end
    checks++; if (busy_o !== 1'b0)         begin errors++; $display("FAIL rst_busy got %0h want 0", busy_o); end
    checks++; if (sample_idx_o !== 3'd0)   begin errors++; $display("FAIL rst_sample_idx got %0h want 0", sample_idx_o); end
    checks++; if (timeout_err_o !== 1'b0)  begin errors++; $display("FAIL rst_err got %0h want 0", timeout_err_o); end
    rst_n_i = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_shot();
    int c, t0, v0;
    bit ok;
    vals_q.delete(); vals_q.push_back(12'h5A3); val_base = done_count;
    conv_len = 20; t0 = trig_count; v0 = valid_count;
    pulse_ss(2'd0, c);
    checks++; if (last_trig_cyc != c + 1) begin errors++; $display("FAIL ss_trig_latency got %0d want %0d", last_trig_cyc, c + 1); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ss_idle_timeout got busy want idle"); end
    checks++; if (trig_count - t0 != 1)  begin errors++; $display("FAIL ss_trig_count got %0d want 1", trig_count - t0); end
    checks++; if (valid_count - v0 != 1) begin errors++; $display("FAIL ss_valid_count got %0d want 1", valid_count - v0); end
    checks++; if (last_valid_val !== 12'h5A3) begin errors++; $display("FAIL ss_result got %0h want 5a3", last_valid_val); end
    checks++; if (last_valid_cyc != last_done_cyc + 2) begin errors++; $display("FAIL ss_valid_latency got %0d want %0d", last_valid_cyc, last_done_cyc + 2); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ss_busy got %0h want 0", busy_o); end
    model_result = 12'h5A3;
  endtask

  task automatic test_averaging();
    int fixed_a[4] = '{100, 101, 102, 105};
    int c, t0, v0, n, sum, v;
    logic [1:0] avg;
    bit ok;
    for (int b = 0; b < 8; b++) begin
      avg = (b < 2) ? 2'd2 : 2'($urandom_range(0, 3));
      n = 1 << avg;
      sum = 0;
      vals_q.delete();
      for (int i = 0; i < n; i++) begin
        v = (b == 0) ? fixed_a[i] : (b == 1) ? 4095 : int'($urandom_range(0, 4095));
        vals_q.push_back(12'(v));
        sum += v;
      end
      val_base = done_count;
      conv_len = $urandom_range(4, 25);
      t0 = trig_count; v0 = valid_count;
      pulse_ss(avg, c);
      wait_idle(n * (conv_len + 10) + 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL avg_idle_timeout burst %0d", b); end
      checks++; if (trig_count - t0 != n) begin errors++; $display("FAIL avg_trig_count burst %0d got %0d want %0d", b, trig_count - t0, n); end
      checks++; if (valid_count - v0 != 1) begin errors++; $display("FAIL avg_valid_count burst %0d got %0d want 1", b, valid_count - v0); end
      checks++; if (last_valid_val !== 12'(sum >> avg)) begin errors++; $display("FAIL avg_result burst %0d got %0d want %0d", b, last_valid_val, sum >> avg); end
      checks++; if (last_valid_cyc != last_done_cyc + 2) begin errors++; $display("FAIL avg_valid_latency burst %0d got %0d want %0d", b, last_valid_cyc, last_done_cyc + 2); end
      model_result = 12'(sum >> avg);
    end
  endtask

  task automatic test_continuous();
    int periods[3];
    int p, eff, t0, v0, spacing, c;
    periods[0] = 50; periods[1] = 0; periods[2] = $urandom_range(2, 40);
    for (int k = 0; k < 3; k++) begin
      p = periods[k];
      eff = (p == 0) ? 1 : p;
      period_i = PERIOD_W'(p);
      avg_log2_i = 2'd0;
      conv_len = $urandom_range(6, 20);
      vals_q.delete();
      for (int i = 0; i < 4; i++) vals_q.push_back(12'($urandom_range(0, 4095)));
      val_base = done_count;
      t0 = trig_count; v0 = valid_count;
      continuous_i = 1'b1;
      c = cyc;
      for (int i = 0; i < 600 && trig_count < t0 + 2; i++) tick();
      checks++; if (trig_count < t0 + 2) begin errors++; $display("FAIL cont_second_trigger p=%0d got %0d triggers want 2", p, trig_count - t0); end
      else begin
        checks++; if (trig_cycles[t0] != c + 1) begin errors++; $display("FAIL cont_first_latency p=%0d got %0d want %0d", p, trig_cycles[t0], c + 1); end
        spacing = trig_cycles[t0 + 1] - trig_cycles[t0];
        checks++; if (spacing != 3 + conv_len + eff + 2) begin errors++; $display("FAIL cont_spacing p=%0d got %0d want %0d", p, spacing, 3 + conv_len + eff + 2); end
        checks++; if (valid_count - v0 != 1 || last_valid_val !== vals_q[0]) begin errors++; $display("FAIL cont_result1 p=%0d got %0h want %0h", p, last_valid_val, vals_q[0]); end
      end
      for (int i = 0; i < 400 && valid_count < v0 + 2; i++) tick();
      continuous_i = 1'b0;
      checks++; if (valid_count != v0 + 2 || last_valid_val !== vals_q[1]) begin errors++; $display("FAIL cont_result2 p=%0d got %0h want %0h", p, last_valid_val, vals_q[1]); end
      repeat (3 + conv_len + eff + 20) tick();
      checks++; if (trig_count != t0 + 2) begin errors++; $display("FAIL cont_stop_trig p=%0d got %0d want %0d", p, trig_count - t0, 2); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cont_stop_busy p=%0d got %0h want 0", p, busy_o); end
      model_result = vals_q[1];
    end
    period_i = '0;
  endtask

  task automatic test_timeout();
    int c, tc, v0;
    timeout_i = TIMEOUT_W'(100);
    never_done = 1'b1;
    v0 = valid_count;
    pulse_ss(2'd0, c);
    tc = c + 1;
    checks++; if (last_trig_cyc != tc) begin errors++; $display("FAIL to_trigger got %0d want %0d", last_trig_cyc, tc); end
    while (cyc < tc + 100) tick();
    checks++; if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL to_early got %0h want 0", timeout_err_o); end
    tick();
    checks++; if (timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_set got %0h want 1", timeout_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL to_busy got %0h want 0", busy_o); end
    checks++; if (valid_count != v0) begin errors++; $display("FAIL to_no_valid got %0d want %0d", valid_count, v0); end
    checks++; if (result_o !== model_result) begin errors++; $display("FAIL to_result_held got %0h want %0h", result_o, model_result); end
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    checks++; if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL to_clear got %0h want 0", timeout_err_o); end
    pulse_ss(2'd0, c);
    tc = c + 1;
    while (cyc < tc + 100) tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    checks++; if (timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_set_wins got %0h want 1", timeout_err_o); end
    checks++; if (valid_count != v0) begin errors++; $display("FAIL to_no_valid2 got %0d want %0d", valid_count, v0); end
    never_done = 1'b0;
    restore_ready = 1'b1; tick(); restore_ready = 1'b0;
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    timeout_i = '0;
    tick();
  endtask

  task automatic test_abort();
    int c, t0, v0, t3;
    bit ok;
    conv_len = 20;
    vals_q.delete();
    for (int i = 0; i < 4; i++) vals_q.push_back(12'($urandom_range(0, 4095)));
    val_base = done_count;
    t0 = trig_count; v0 = valid_count;
    pulse_ss(2'd2, c);
    for (int i = 0; i < 300 && trig_count < t0 + 3; i++) tick();
    checks++; if (trig_count < t0 + 3) begin errors++; $display("FAIL abort_third_trigger got %0d want 3", trig_count - t0); end
    t3 = last_trig_cyc;
    while (cyc < t3 + 6) tick();
    checks++; if (sample_idx_o !== 3'd2) begin errors++; $display("FAIL abort_sample_idx got %0d want 2", sample_idx_o); end
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle got %0h want 0", busy_o); end
    while (cyc < t3 + 3 + conv_len + 10) tick();
    checks++; if (trig_count != t0 + 3) begin errors++; $display("FAIL abort_trig got %0d want 3", trig_count - t0); end
    checks++; if (valid_count != v0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", valid_count - v0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_late_ready got busy %0h want 0", busy_o); end
    vals_q.delete();
    vals_q.push_back(12'd10); vals_q.push_back(12'd20); vals_q.push_back(12'd30); vals_q.push_back(12'd40);
    val_base = done_count;
    t0 = trig_count; v0 = valid_count;
    pulse_ss(2'd2, c);
    checks++; if (sample_idx_o !== 3'd0) begin errors++; $display("FAIL abort_restart_idx got %0d want 0", sample_idx_o); end
    wait_idle(300, ok);
    checks++; if (!ok || trig_count - t0 != 4) begin errors++; $display("FAIL abort_restart_trig got %0d want 4", trig_count - t0); end
    checks++; if (valid_count - v0 != 1 || last_valid_val !== 12'd25) begin errors++; $display("FAIL abort_restart_result got %0d want 25", last_valid_val); end
    model_result = 12'd25;
  endtask

  task automatic test_busy_ignore();
    int c, t0, v0;
    bit ok;
    logic [COUNT_W-1:0] v;
    v = 12'($urandom_range(1, 4095));
    vals_q.delete(); vals_q.push_back(v); val_base = done_count;
    conv_len = 12;
    t0 = trig_count; v0 = valid_count;
    pulse_ss(2'd0, c);
    while (cyc < c + 8) tick();
    pulse_ss(2'd3, c);
    wait_idle(100, ok);
    repeat (30) tick();
    checks++; if (trig_count - t0 != 1) begin errors++; $display("FAIL busy_ss_trig got %0d want 1", trig_count - t0); end
    checks++; if (valid_count - v0 != 1 || last_valid_val !== v) begin errors++; $display("FAIL busy_ss_result got %0h want %0h", last_valid_val, v); end
    model_result = v;
  endtask

  task automatic test_reset_mid();
    int c;
    vals_q.delete(); vals_q.push_back(12'h123); val_base = done_count;
    conv_len = 20;
    timeout_i = TIMEOUT_W'(5000);
    pulse_ss(2'd0, c);
    while (cyc < c + 10) tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstm_busy_before got %0h want 1", busy_o); end
    rst_n_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0)         begin errors++; $display("FAIL rstm_busy got %0h want 0", busy_o); end
    checks++; if (trigger_o !== 1'b0)      begin errors++; $display("FAIL rstm_trigger got %0h want 0", trigger_o); end
    checks++; if (result_o !== '0)         begin errors++; $display("FAIL rstm_result got %0h want 0", result_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rstm_valid got %0h want 0", result_valid_o); end
    checks++; if (sample_idx_o !== 3'd0)   begin errors++; $display("FAIL rstm_idx got %0h want 0", sample_idx_o); end
    repeat (2) tick();
    rst_n_i = 1'b1;
    timeout_i = '0;
    tick();
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_shot();
    test_averaging();
    test_continuous();
    test_timeout();
    test_abort();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
